dmem_port_arbiter: RTL and testbench

//  Shares one synchronous data-memory port among NUM_CH requesters: the processor, the VGA

---
 rtl/dmem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares one synchronous data-memory port among NUM_CH requesters
//
// Purpose: grants at most one request per cycle (round-robin or fixed priority),
// drives the single memory port, and routes each read result back to its owner
// through a READ_LAT-deep tag pipeline.
//
// Ports:
//   clock     in   master clock, rising edge
//   reset     in   asynchronous active-high reset
//   req       in   per-channel request, held until gnt
//   we        in   per-channel write enable, qualified by req
//   addr      in   per-channel word address, ch i at [i*ADDR_W +: ADDR_W]
//   wdata     in   per-channel write data, ch i at [i*DATA_W +: DATA_W]
//   gnt       out  one-hot grant, access issued this cycle
//   rvalid    out  one-hot, rdata belongs to that channel
//   rdata     out  shared read data (mem_q)
//   mem_addr  out  memory address
//   mem_wdata out  memory write data
//   mem_wren  out  memory write enable
//   mem_q     in   memory read data, READ_LAT cycles after the address

module dmem_port_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 1,
  parameter int PRIO_MODE = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_wren,
  input  logic [DATA_W-1:0]        mem_q
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  win_idx;
  logic              win_valid;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  int                cand;

  logic [READ_LAT-1:0] tag_v;
  logic [IDX_W-1:0]    tag_id [READ_LAT];

  // Search starts at rr_ptr (or 0 in fixed-priority mode) and wraps; the first
  // requester found wins. Reset suppresses any winner.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (PRIO_MODE != 0) ? i : int'(rr_ptr) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
    if (reset) win_valid = 1'b0;
  end

  always_comb begin
    gnt = '0;
    if (win_valid) gnt[win_idx] = 1'b1;
  end

  assign win_addr  = addr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_wdata = wdata[int'(win_idx)*DATA_W +: DATA_W];

  // Without a winner the port shows the last issued address/data from a
  // register, so the memory inputs do not follow idle request lines.
  assign mem_addr  = win_valid ? win_addr : addr_q;
  assign mem_wdata = win_valid ? win_wdata : wdata_q;
  assign mem_wren  = win_valid & we[win_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (win_valid) begin
      addr_q  <= win_addr;
      wdata_q <= win_wdata;
      if (PRIO_MODE == 0)
        rr_ptr <= (win_idx == IDX_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Tag pipeline: stage 0 is loaded at the end of the grant cycle, so the last
  // stage is valid exactly READ_LAT cycles after gnt, aligned with mem_q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_v <= '0;
      for (int s = 0; s < READ_LAT; s++) tag_id[s] <= '0;
    end else begin
      tag_v[0]  <= win_valid & ~we[win_idx];
      tag_id[0] <= win_idx;
      for (int s = 1; s < READ_LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (tag_v[READ_LAT-1]) rvalid[tag_id[READ_LAT-1]] = 1'b1;
  end

  assign rdata = mem_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req   = '0;
  logic [3:0]   we    = '0;
  logic [47:0]  addr  = '0;
  logic [127:0] wdata = '0;

  logic [3:0]  gnt, rvalid, fp_gnt, fp_rvalid;
  logic [31:0] rdata, mem_wdata, mem_q, fp_rdata, fp_mem_wdata, fp_mem_q;
  logic [11:0] mem_addr, fp_mem_addr;
  logic        mem_wren, fp_mem_wren;

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;

  typedef struct { int cyc; int ch; logic [31:0] d; } exp_t;
  exp_t sbq[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_port_arbiter #(.NUM_CH(4), .ADDR_W(12), .DATA_W(32), .READ_LAT(2), .PRIO_MODE(0)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q));

  dmem_port_arbiter #(.NUM_CH(4), .ADDR_W(12), .DATA_W(32), .READ_LAT(1), .PRIO_MODE(1)) dut_fp (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(fp_gnt), .rvalid(fp_rvalid), .rdata(fp_rdata), .mem_addr(fp_mem_addr),
    .mem_wdata(fp_mem_wdata), .mem_wren(fp_mem_wren), .mem_q(fp_mem_q));

  // Memory model with registered read path (two cycles address -> q).
  logic [31:0] mem [0:4095];
  logic [31:0] q1, q2;
  always @(posedge clock) begin
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    q1 <= mem[mem_addr];
    q2 <= q1;
  end
  assign mem_q = q2;

  logic [31:0] fp_q;
  always @(posedge clock) fp_q <= {20'hA5A5A, fp_mem_addr};
  assign fp_mem_q = fp_q;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_ch(input int ch, input logic r, input logic w,
                        input logic [11:0] a, input logic [31:0] d);
    req[ch] = r;
    we[ch]  = w;
    addr[ch*12 +: 12]  = a;
    wdata[ch*32 +: 32] = d;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard consumer plus per-cycle grant invariants on the round-robin DUT.
  always @(negedge clock) begin
    exp_t e;
    if (rvalid !== 4'b0000) begin
      compared++;
      assert (sbq.size() != 0) else begin
        failed++;
        $error("FAIL unexpected_rvalid: observed=%0h expected=0 at cycle %0d", rvalid, cyc);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("rvalid_onehot", rvalid, 4'b0001 << e.ch);
        check("rvalid_cycle", cyc, e.cyc);
        check("rdata", rdata, e.d);
      end
    end
    check("gnt_onehot0", $onehot0(gnt), 1'b1);
    check("gnt_implies_req", gnt & ~req, 4'b0000);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE0000 | i;
    mem[12'h010] = 32'hDEADBEEF;

    // Reset with all channels requesting (writes, so no reads can leak out).
    for (int c = 0; c < 4; c++) set_ch(c, 1'b1, 1'b1, 12'h100 + 12'(c), 32'h5000 + c);
    repeat (2) @(negedge clock);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_fp_gnt", fp_gnt, 4'b0000);
    check("rst_mem_wren", mem_wren, 1'b0);
    check("rst_rvalid", rvalid, 4'b0000);
    check("rst_mem_addr", mem_addr, 12'h000);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    check("rel_gnt", gnt, 4'b0001);
    check("rel_fp_gnt", fp_gnt, 4'b0001);
    check("rel_mem_wren", mem_wren, 1'b1);
    check("rel_mem_addr", mem_addr, 12'h100);
    next_cycle();
    req = 4'b0000;
    @(negedge clock);
    check("idle_gnt", gnt, 4'b0000);
    check("idle_wren", mem_wren, 1'b0);
    check("idle_addr_hold", mem_addr, 12'h100);
    check("idle_wdata_hold", mem_wdata, 32'h5000);

    // Single read by ch2, two-cycle latency.
    next_cycle();
    set_ch(2, 1'b1, 1'b0, 12'h010, 32'h0);
    @(negedge clock);
    check("rd_gnt", gnt, 4'b0100);
    check("rd_mem_addr", mem_addr, 12'h010);
    check("rd_wren", mem_wren, 1'b0);
    sbq.push_back('{cyc + 2, 2, 32'hDEADBEEF});
    next_cycle();
    req = 4'b0000;
    repeat (3) next_cycle();

    // Round-robin fairness from a fresh rr_ptr.
    reset = 1'b1;
    for (int c = 0; c < 4; c++) set_ch(c, 1'b1, 1'b0, 12'h020 + 12'(c), 32'h0);
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("rr_gnt", gnt, 4'b0001 << (k % 4));
      sbq.push_back('{cyc + 2, k % 4, 32'hC0DE0020 | (k % 4)});
      next_cycle();
    end
    req = 4'b0000;

    // Fixed priority on the second instance (writes keep the first quiet).
    for (int c = 0; c < 4; c++) set_ch(c, 1'b0, 1'b1, 12'h100 + 12'(c), 32'h6000 + c);
    req = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("fp_gnt_both", fp_gnt, 4'b0010);
      next_cycle();
    end
    req = 4'b0100;
    @(negedge clock);
    check("fp_gnt_ch2", fp_gnt, 4'b0100);
    next_cycle();
    req = 4'b0000;
    repeat (2) next_cycle();

    // Write then read of the same address on the next cycle.
    set_ch(0, 1'b1, 1'b1, 12'h005, 32'h12345678);
    @(negedge clock);
    check("wr_gnt", gnt, 4'b0001);
    check("wr_wren", mem_wren, 1'b1);
    check("wr_wdata", mem_wdata, 32'h12345678);
    next_cycle();
    req = 4'b0000;
    set_ch(3, 1'b1, 1'b0, 12'h005, 32'h0);
    @(negedge clock);
    check("raw_gnt", gnt, 4'b1000);
    sbq.push_back('{cyc + 2, 3, 32'h12345678});
    next_cycle();
    req = 4'b0000;
    repeat (4) next_cycle();

    // Reset while two reads are in flight: both must vanish.
    set_ch(1, 1'b1, 1'b0, 12'h030, 32'h0);
    @(negedge clock);
    check("mf_gnt_t0", gnt, 4'b0010);
    next_cycle();
    req = 4'b0000;
    set_ch(2, 1'b1, 1'b0, 12'h031, 32'h0);
    @(negedge clock);
    check("mf_gnt_t1", gnt, 4'b0100);
    next_cycle();
    req = 4'b0000;
    reset = 1'b1;
    @(negedge clock);
    check("mf_rvalid_rst", rvalid, 4'b0000);
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("mf_rvalid_after", rvalid, 4'b0000);
      next_cycle();
    end
    for (int c = 0; c < 4; c++) set_ch(c, 1'b1, 1'b1, 12'h100 + 12'(c), 32'h7000 + c);
    @(negedge clock);
    check("mf_rr_ptr_zero", gnt, 4'b0001);
    next_cycle();
    req = 4'b0000;

    repeat (4) next_cycle();
    check("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
